// File: rtl/br_flow_serializer_reg.sv
// Registered wide-to-narrow flow serializer: one holding register sliced onto the pop side,
// with the next push overlapping the final slice so the pop side sustains one flit per cycle.
module br_flow_serializer_reg #(
    parameter int PushWidth                     = 2,
    parameter int PopWidth                      = 1,
    parameter int MetadataWidth                 = 1,
    parameter bit SerializeMostSignificantFirst = 1'b1,
    parameter bit EnableAssertFinalNotValid     = 1'b1,
    localparam int SerializationRatio = PushWidth / PopWidth,
    localparam int SerFlitIdWidth     = (SerializationRatio > 1) ? $clog2(SerializationRatio) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      push_ready,
    input  logic                      push_valid,
    input  logic [PushWidth-1:0]      push_data,
    input  logic                      push_last,
    input  logic [SerFlitIdWidth-1:0] push_last_dont_care_count,
    input  logic [MetadataWidth-1:0]  push_metadata,
    input  logic                      pop_ready,
    output logic                      pop_valid,
    output logic [PopWidth-1:0]       pop_data,
    output logic                      pop_last,
    output logic [MetadataWidth-1:0]  pop_metadata,
    output logic [SerFlitIdWidth-1:0] pop_flit_id
);

    localparam logic [SerFlitIdWidth-1:0] LastId = SerFlitIdWidth'(SerializationRatio - 1);

    logic                                        valid_q;
    logic [SerFlitIdWidth-1:0]                   flit_id_q;
    logic [PushWidth-1:0]                        data_q;
    logic                                        last_q;
    logic [SerFlitIdWidth-1:0]                   dcc_q;
    logic [MetadataWidth-1:0]                    meta_q;

    logic                                        is_final;
    logic [SerFlitIdWidth-1:0]                   slice_idx;
    logic [SerializationRatio-1:0][PopWidth-1:0] slices;
    logic                                        push_fire;
    logic                                        pop_fire;

    // The sum wraps at SerFlitIdWidth bits; legal dcc values keep it from ever wrapping.
    always_comb begin
        is_final = 1'b1;
        if (SerializationRatio > 1) begin
            is_final = (flit_id_q + dcc_q) == LastId;
        end
    end

    assign slices    = data_q;
    assign slice_idx = SerializeMostSignificantFirst ? (LastId - flit_id_q) : flit_id_q;

    assign pop_valid    = valid_q;
    assign pop_data     = slices[slice_idx];
    assign pop_last     = valid_q && last_q && is_final;
    assign pop_metadata = meta_q;
    assign pop_flit_id  = flit_id_q;

    // Registered state and pop_ready only; nothing from push_* reaches push_ready.
    assign push_ready = !rst && (!valid_q || (pop_ready && is_final));
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_ready && valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            flit_id_q <= '0;
        end else if (push_fire) begin
            valid_q   <= 1'b1;
            flit_id_q <= '0;
        end else if (pop_fire) begin
            if (is_final) begin
                valid_q   <= 1'b0;
                flit_id_q <= '0;
            end else begin
                flit_id_q <= flit_id_q + 1'b1;
            end
        end
    end

    // NOTE: payload registers are qualified by valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            data_q <= push_data;
            last_q <= push_last;
            dcc_q  <= push_last_dont_care_count;
            meta_q <= push_metadata;
        end
    end

`ifndef SYNTHESIS
    if (SerializationRatio > 1) begin : g_dcc_checks
        assert property (@(posedge clk) disable iff (rst)
            push_valid && push_last |-> int'(push_last_dont_care_count) < SerializationRatio);
        assert property (@(posedge clk) disable iff (rst)
            push_valid && !push_last |-> push_last_dont_care_count == '0);
    end

    assert property (@(posedge clk) disable iff (rst)
        push_valid && !push_ready |=> push_valid &&
            $stable({push_data, push_last, push_last_dont_care_count, push_metadata}));

    assert property (@(posedge clk) disable iff (rst) pop_last |-> last_q);
    assert property (@(posedge clk) disable iff (rst) int'(flit_id_q) <= SerializationRatio - 1);
    assert property (@(posedge clk) disable iff (rst)
        push_fire |-> !valid_q || (pop_ready && is_final));

    cover property (@(posedge clk) disable iff (rst) push_fire && pop_fire);
    cover property (@(posedge clk) disable iff (rst) push_fire && push_last_dont_care_count != '0);
    cover property (@(posedge clk) disable iff (rst) valid_q && !pop_ready && !is_final);

    if (EnableAssertFinalNotValid) begin : g_final_check
        final begin
            assert (!push_valid && !pop_valid);
        end
    end
`endif

endmodule
